// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered duty
// per channel with optional triangle fade, per-channel output polarity.
module pwm_multi #(
  parameter int R       = 8,
  parameter int N       = 4,
  parameter int CH_W    = 2,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [R-1:0]       period,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [R-1:0]       duty_data,
  input  logic [N-1:0]       fade_en,
  input  logic [N-1:0]       pol,
  output logic [N-1:0]       pwm_out,
  output logic               period_tick
);

  logic [PRESC_W-1:0] psc_reg;
  logic [R-1:0]       q_reg;
  logic               period_tick_reg;
  logic               tick;
  logic               wrap;

  assign tick        = en && (psc_reg == prescale);
  assign wrap        = tick && (q_reg == period);
  assign period_tick = period_tick_reg;

  // psc beyond a freshly lowered prescale falls back to 0 without a tick;
  // q above a lowered period rolls over naturally, which is not a wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_reg         <= '0;
      q_reg           <= '0;
      period_tick_reg <= 1'b0;
    end else begin
      period_tick_reg <= wrap;
      if (!en) begin
        psc_reg <= '0;
        q_reg   <= '0;
      end else begin
        psc_reg <= (psc_reg >= prescale) ? '0 : psc_reg + 1'b1;
        if (tick)
          q_reg <= (q_reg == period) ? '0 : q_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [R-1:0] pending_reg;
      logic [R-1:0] active_reg;
      logic         dir_down_reg;
      logic         out_reg;

      assign pwm_out[gi] = out_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pending_reg  <= '0;
          active_reg   <= '0;
          dir_down_reg <= 1'b0;
          out_reg      <= 1'b0;
        end else begin
          if (duty_wr && (duty_ch == CH_W'(gi)))
            pending_reg <= duty_data;

          // Shadow only moves at a wrap; fade steps once per period toward/away from the peak.
          if (wrap) begin
            if (!fade_en[gi]) begin
              active_reg   <= pending_reg;
              dir_down_reg <= 1'b0;
            end else if (!dir_down_reg) begin
              if (active_reg >= pending_reg) begin
                active_reg   <= pending_reg;
                dir_down_reg <= 1'b1;
              end else begin
                active_reg <= active_reg + 1'b1;
              end
            end else if (active_reg == '0) begin
              dir_down_reg <= 1'b0;
            end else begin
              active_reg <= active_reg - 1'b1;
            end
          end

          out_reg <= en ? ((q_reg < active_reg) ^ pol[gi]) : pol[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: duty patterns, edge duties, prescaling,
// wrap-aligned writes, fade ramp and asynchronous reset.
module tb_pwm_multi;
  localparam int R       = 8;
  localparam int N       = 4;
  localparam int CH_W    = 2;
  localparam int PRESC_W = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic [R-1:0]       period = 8'd9;
  logic               duty_wr = 1'b0;
  logic [CH_W-1:0]    duty_ch = '0;
  logic [R-1:0]       duty_data = '0;
  logic [N-1:0]       fade_en = '0;
  logic [N-1:0]       pol = '0;
  logic [N-1:0]       pwm_out;
  logic               period_tick;

  int          errors = 0;
  int          checks = 0;
  int          hi [N];
  int          nticks;
  logic [31:0] pat0;
  logic [31:0] patt;
  int          fexp [9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};

  pwm_multi #(.R(R), .N(N), .CH_W(CH_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .prescale(prescale),
    .period(period), .duty_wr(duty_wr), .duty_ch(duty_ch),
    .duty_data(duty_data), .fade_en(fade_en), .pol(pol),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles, accumulating high counts and ch0/period_tick bit patterns.
  task automatic run(input int n);
    for (int c = 0; c < N; c++) hi[c] = 0;
    nticks = 0;
    pat0   = '0;
    patt   = '0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < N; c++) hi[c] += int'(pwm_out[c]);
      nticks += int'(period_tick);
      pat0 = {pat0[30:0], pwm_out[0]};
      patt = {patt[30:0], period_tick};
    end
  endtask

  task automatic wait_ptick();
    for (int k = 0; k < 2000; k++) begin
      step();
      if (period_tick) return;
    end
    check("ptick_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_duty(input int ch, input int data);
    duty_wr   = 1'b1;
    duty_ch   = CH_W'(ch);
    duty_data = R'(data);
    step();
    duty_wr   = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_ptick", 32'(period_tick), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_pwm", 32'(pwm_out), 32'd0);
    $display("reset: done");

    // Basic duty 3 of 10
    en = 1'b1;
    write_duty(0, 3);
    wait_ptick();
    run(10);
    check("d3_pattern", pat0, 32'h380);
    check("d3_ptick_pat", patt, 32'h1);
    run(20);
    check("d3_hi20", 32'(hi[0]), 32'd6);
    check("d3_ticks20", 32'(nticks), 32'd2);
    check("ch1_idle", 32'(hi[1]), 32'd0);
    $display("duty3: hi=%0d ticks=%0d", hi[0], nticks);

    // Edge duties
    write_duty(1, 0);
    write_duty(2, 12);
    wait_ptick();
    run(10);
    check("duty0_low", 32'(hi[1]), 32'd0);
    check("duty12_high", 32'(hi[2]), 32'd10);
    check("ch0_keep", 32'(hi[0]), 32'd3);
    pol = 4'b0100;
    step();
    run(10);
    check("duty12_inv", 32'(hi[2]), 32'd0);
    check("ch0_keep2", 32'(hi[0]), 32'd3);
    en  = 1'b0;
    pol = 4'b1010;
    step();
    step();
    check("en0_pol", 32'(pwm_out), 32'hA);
    run(20);
    check("en0_ticks", 32'(nticks), 32'd0);
    check("en0_ch1", 32'(hi[1]), 32'd20);
    check("en0_ch0", 32'(hi[0]), 32'd0);
    $display("edges: en=0 pwm_out=%b", pwm_out);

    // Prescale 2, period 3, duty 2
    pol      = '0;
    prescale = 16'd2;
    period   = 8'd3;
    write_duty(0, 2);
    en = 1'b1;
    wait_ptick();
    run(12);
    check("psc_pattern", pat0, 32'hFC0);
    check("psc_ptick_pat", patt, 32'h1);
    check("psc_ch2_full", 32'(hi[2]), 32'd12);
    $display("prescale: pattern=%b", pat0[11:0]);

    // Write landing exactly on a wrap
    prescale = 16'd0;
    period   = 8'd9;
    write_duty(0, 3);
    wait_ptick();
    repeat (9) step();
    write_duty(0, 5);
    check("wr_on_wrap_ptick", 32'(period_tick), 32'd1);
    run(10);
    check("wr_on_wrap_old", 32'(hi[0]), 32'd3);
    run(10);
    check("wr_on_wrap_new", 32'(hi[0]), 32'd5);
    write_duty(0, 7);
    run(9);
    check("midwr_old", 32'(hi[0]), 32'd4);
    check("midwr_ticks", 32'(nticks), 32'd1);
    run(10);
    check("midwr_new", 32'(hi[0]), 32'd7);
    $display("wrap write: duty now %0d", hi[0]);

    // Fade on ch3, peak 3, period 3
    en      = 1'b0;
    fade_en = 4'b1000;
    period  = 8'd3;
    step();
    write_duty(3, 3);
    en = 1'b1;
    wait_ptick();
    for (int k = 0; k < 9; k++) begin
      run(4);
      check("fade_step", 32'(hi[3]), 32'(fexp[k]));
      check("fade_ticks", 32'(nticks), 32'd1);
      $display("fade: wrap %0d active=%0d", k + 1, hi[3]);
    end
    step();
    fade_en = '0;
    run(3);
    run(4);
    check("fade_clear", 32'(hi[3]), 32'd3);

    // Asynchronous reset mid-period
    check("pre_reset_ch0", 32'(pwm_out[0]), 32'd1);
    wait_ptick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_ptick", 32'(period_tick), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run(20);
    check("post_rst_ch0", 32'(hi[0]), 32'd0);
    check("post_rst_ch2", 32'(hi[2]), 32'd0);
    check("post_rst_ticks", 32'(nticks), 32'd5);
    write_duty(2, 2);
    wait_ptick();
    run(4);
    check("post_rst_new", 32'(hi[2]), 32'd2);
    check("post_rst_ch0b", 32'(hi[0]), 32'd0);
    $display("reset: ch2=%0d after rewrite", hi[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator: successor to the single-channel fixed-period PWM used for LED dimming. Provides N independent channels sharing one clock prescaler and one programmable-period counter, with glitch-free double-buffered duty updates, per-channel output polarity, and a per-channel breathing (fade) mode. Sits between the register/control logic and the LED pads.

## Interface
- R, 8: counter and duty width in bits
- N, 4: number of PWM channels
- CH_W, 2: channel index width; N ≤ 2**CH_W
- PRESC_W, 16: prescaler width in bits

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global enable
- prescale  in  PRESC_W  tick divider; one counter tick every prescale+1 clk
- period  in  R  period counter terminal value; period length = period+1 ticks
- duty_wr  in  1  single-cycle write strobe for pending duty
- duty_ch  in  CH_W  channel addressed by duty_wr; writes to index ≥ N are ignored
- duty_data  in  R  duty value written to pending[duty_ch]
- fade_en  in  N  per-channel breathing mode enable
- pol  in  N  per-channel polarity; 1 inverts the output
- pwm_out  out  N  registered PWM outputs
- period_tick  out  1  one-clk pulse on each period wrap

## Operation
- Prescaler: psc counts 0..prescale; tick asserted the clk where psc == prescale, psc then returns to 0. prescale = 0 gives tick every clk. A prescale change takes effect immediately; if psc > new prescale, psc wraps to 0 on the next clk, with no tick on that clk.
- Period counter q (R bits): on tick, q <= (q == period) ? 0 : q+1. Wrap = tick && q == period. If period is lowered below the current q, q counts up through 2**R-1 and rolls over to 0. That rollover is not a wrap and loads no shadow.
- period_tick is registered: high for one clk, the clk after a wrap.
- Duty buffering: pending[i] <= duty_data when duty_wr and duty_ch == i. active[i] changes only on a wrap. A write in the same clk as a wrap lands in pending and is not loaded until the following wrap.
- Non-fade channel (fade_en[i] = 0), on wrap: active[i] <= pending[i].
- Fade channel (fade_en[i] = 1), on wrap; dir[i] = up or down; pending[i] is the peak.
  - up, active ≥ pending: active <= pending, dir <= down.
  - up, otherwise: active <= active+1.
  - down, active == 0: dir <= up.
  - down, otherwise: active <= active-1.
  - Result is a triangle 0→peak→0 with one step per period. Peak 0 holds at 0.
  - Clearing fade_en: next wrap loads pending directly, dir <= up.
- Compare: raw[i] = (q < active[i]).
  - active = 0: constant low.
  - active > period: constant high (100 %).
- Output: pwm_out[i] <= raw[i] ^ pol[i], registered.
- en = 0: psc and q held at 0, no ticks, no wraps, no period_tick. pwm_out[i] <= pol[i], the inactive level. pending stays writable, active and dir hold.
  - When en rises, counting restarts from q = 0. The first wrap loads the shadows.

## Timing
- Reset values: psc = 0, q = 0, pending = 0, active = 0, dir = up, pwm_out = 0, period_tick = 0.
- Reset is asynchronous and may assert mid-period. All state returns to reset values immediately. Pending writes are lost.
- Latency: pwm_out reflects q and active one clk after they change. period_tick is one clk after the wrap.
- Duty steady state with prescale = 0: pwm_out[i] active for min(active, period+1) clk out of every period+1 clk.
- Tick timing with prescale = p: each q value lasts p+1 clk.
- New duty becomes visible at most one full period plus one clk after duty_wr.

## Test plan
- Reset, then en = 1, prescale = 0, period = 9, write ch0 = 3. From the first wrap onward, pwm_out[0] is high 3 clk of every 10, and period_tick pulses every 10 clk.
- Edge duties with period = 9: ch1 = 0 gives constant 0; ch2 = 12 gives constant 1; ch2 with pol[2] = 1 gives constant 0. Every channel outputs pol while en = 0.
- Prescale = 2, period = 3, duty = 2: each q step lasts 3 clk, and the output is high 6 of every 12 clk.
- Write duty 5 in the exact clk of a wrap: the old duty persists one more period and 5 appears from the next wrap. A mid-period write never changes the current period.
- Fade: period = 3, peak = 3, fade_en[3] = 1. Active over successive wraps is 1, 2, 3, 3, 2, 1, 0, 0, 1, … Clearing fade_en mid-ramp loads 3 at the next wrap.
- Assert reset_n low mid-period with active = 7: pwm_out and period_tick go 0 immediately. After release with en = 1, outputs stay low until new writes and a wrap.
